// File: rtl/exu_pkg.sv
// Shared constants for the execute unit: ALU ops, mul/div funct3, branch modes, operand-B selects.
package exu_pkg;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b1000;
  localparam logic [3:0] ALU_SLL   = 4'b0001;
  localparam logic [3:0] ALU_SRL   = 4'b0101;
  localparam logic [3:0] ALU_SRA   = 4'b1101;
  localparam logic [3:0] ALU_SLT   = 4'b0010;
  localparam logic [3:0] ALU_SLTU  = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_OR    = 4'b0110;
  localparam logic [3:0] ALU_AND   = 4'b0111;
  localparam logic [3:0] ALU_COPYB = 4'b1111;
  localparam logic [3:0] ALU_ANDN  = 4'b1110;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_JAL  = 3'b001;
  localparam logic [2:0] BR_JALR = 3'b010;
  localparam logic [2:0] BR_BEQ  = 3'b100;
  localparam logic [2:0] BR_BNE  = 3'b101;
  localparam logic [2:0] BR_BLT  = 3'b110;
  localparam logic [2:0] BR_BGE  = 3'b111;

  localparam logic [1:0] BSRC_SRC2 = 2'b00;
  localparam logic [1:0] BSRC_FOUR = 2'b01;
  localparam logic [1:0] BSRC_IMM  = 2'b10;
  localparam logic [1:0] BSRC_CSR  = 2'b11;

endpackage

// File: rtl/exu_alu.sv
// Combinational 64-bit ALU with RV64 word-op variants and a zero flag.
module exu_alu
  import exu_pkg::*;
(
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic [3:0]  op,
  input  logic        word,
  output logic [63:0] result,
  output logic        zero
);

  logic [63:0] res64;
  logic [31:0] res32;
  logic [31:0] a32, b32;

  assign a32 = a[31:0];
  assign b32 = b[31:0];

  always_comb begin
    res64 = '0;
    case (op)
      ALU_ADD:   res64 = a + b;
      ALU_SUB:   res64 = a - b;
      ALU_SLL:   res64 = a << b[5:0];
      ALU_SRL:   res64 = a >> b[5:0];
      ALU_SRA:   res64 = $signed(a) >>> b[5:0];
      ALU_SLT:   res64 = {63'b0, $signed(a) < $signed(b)};
      ALU_SLTU:  res64 = {63'b0, a < b};
      ALU_XOR:   res64 = a ^ b;
      ALU_OR:    res64 = a | b;
      ALU_AND:   res64 = a & b;
      ALU_COPYB: res64 = b;
      ALU_ANDN:  res64 = b & ~a;
      default:   res64 = '0;
    endcase
  end

  // Word ops work on the low halves; SRLW zero-fills from bit 31 before the sign extension.
  always_comb begin
    res32 = '0;
    case (op)
      ALU_ADD:   res32 = a32 + b32;
      ALU_SUB:   res32 = a32 - b32;
      ALU_SLL:   res32 = a32 << b32[4:0];
      ALU_SRL:   res32 = a32 >> b32[4:0];
      ALU_SRA:   res32 = $signed(a32) >>> b32[4:0];
      ALU_SLT:   res32 = {31'b0, $signed(a32) < $signed(b32)};
      ALU_SLTU:  res32 = {31'b0, a32 < b32};
      ALU_XOR:   res32 = a32 ^ b32;
      ALU_OR:    res32 = a32 | b32;
      ALU_AND:   res32 = a32 & b32;
      ALU_COPYB: res32 = b32;
      ALU_ANDN:  res32 = b32 & ~a32;
      default:   res32 = '0;
    endcase
  end

  assign result = word ? {{32{res32[31]}}, res32} : res64;
  assign zero   = (result == 64'd0);

endmodule

// File: rtl/ysyx_220066_exu.sv
// Execute stage: stall-able operand register, ALU, mul/div and next-PC/redirect logic.
// Define EXU_MUL_EN to build the mul/div unit; otherwise every mul/div op flags an error.
module ysyx_220066_exu
  import exu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        block,
  input  logic        valid_in,
  input  logic        error_in,
  input  logic [63:0] src1_in,
  input  logic [63:0] src2_in,
  input  logic [63:0] csr_data_in,
  input  logic [63:0] pc_in,
  input  logic [31:0] imm_in,
  input  logic        ALUAsrc_in,
  input  logic [1:0]  ALUBsrc_in,
  input  logic [5:0]  ALUctr_in,
  input  logic [2:0]  Branch_in,
  input  logic        csr_in,
  input  logic        raise_intr,
  output logic        valid,
  output logic [63:0] result,
  output logic [63:0] nxtpc,
  output logic        is_jmp,
  output logic        error
);

  logic        valid_r, error_r, asrc_r, csr_r;
  logic [63:0] src1_r, src2_r, csr_data_r, pc_r;
  logic [31:0] imm_r;
  logic [1:0]  bsrc_r;
  logic [5:0]  ctr_r;
  logic [2:0]  branch_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r    <= 1'b0;
      error_r    <= 1'b0;
      asrc_r     <= 1'b0;
      csr_r      <= 1'b0;
      src1_r     <= '0;
      src2_r     <= '0;
      csr_data_r <= '0;
      pc_r       <= '0;
      imm_r      <= '0;
      bsrc_r     <= '0;
      ctr_r      <= '0;
      branch_r   <= '0;
    end else if (!block) begin
      valid_r    <= valid_in;
      error_r    <= error_in;
      asrc_r     <= ALUAsrc_in;
      csr_r      <= csr_in;
      src1_r     <= src1_in;
      src2_r     <= src2_in;
      csr_data_r <= csr_data_in;
      pc_r       <= pc_in;
      imm_r      <= imm_in;
      bsrc_r     <= ALUBsrc_in;
      ctr_r      <= ALUctr_in;
      branch_r   <= Branch_in;
    end
  end

  logic [63:0] imm64, op_a, op_b, alu_result;
  logic        alu_zero;

  assign imm64 = {{32{imm_r[31]}}, imm_r};
  assign op_a  = asrc_r ? pc_r : src1_r;

  always_comb begin
    op_b = src2_r;
    case (bsrc_r)
      BSRC_SRC2: op_b = src2_r;
      BSRC_FOUR: op_b = 64'd4;
      BSRC_IMM:  op_b = imm64;
      BSRC_CSR:  op_b = csr_data_r;
      default:   op_b = src2_r;
    endcase
  end

  exu_alu u_alu (
    .a      (op_a),
    .b      (op_b),
    .op     (ctr_r[3:0]),
    .word   (ctr_r[4]),
    .result (alu_result),
    .zero   (alu_zero)
  );

  logic [63:0] md_result;
  logic        md_illegal;

`ifdef EXU_MUL_EN
  logic [127:0] prod_ss, prod_su, prod_uu;
  logic [31:0]  a32, b32, md32;

  assign a32     = op_a[31:0];
  assign b32     = op_b[31:0];
  assign prod_ss = {{64{op_a[63]}}, op_a} * {{64{op_b[63]}}, op_b};
  assign prod_su = {{64{op_a[63]}}, op_a} * {64'd0, op_b};
  assign prod_uu = {64'd0, op_a} * {64'd0, op_b};

  always_comb begin
    md_result  = '0;
    md_illegal = 1'b0;
    md32       = '0;
    if (ctr_r[4]) begin
      case (ctr_r[2:0])
        MD_MUL:  md32 = a32 * b32;
        MD_DIV:  md32 = (b32 == 32'd0) ? '1 :
                        (a32 == 32'h8000_0000 && b32 == '1) ? a32 : $signed(a32) / $signed(b32);
        MD_DIVU: md32 = (b32 == 32'd0) ? '1 : a32 / b32;
        MD_REM:  md32 = (b32 == 32'd0) ? a32 :
                        (a32 == 32'h8000_0000 && b32 == '1) ? '0 : $signed(a32) % $signed(b32);
        MD_REMU: md32 = (b32 == 32'd0) ? a32 : a32 % b32;
        default: md_illegal = 1'b1;
      endcase
      md_result = md_illegal ? '0 : {{32{md32[31]}}, md32};
    end else begin
      case (ctr_r[2:0])
        MD_MUL:    md_result = prod_ss[63:0];
        MD_MULH:   md_result = prod_ss[127:64];
        MD_MULHSU: md_result = prod_su[127:64];
        MD_MULHU:  md_result = prod_uu[127:64];
        MD_DIV:    md_result = (op_b == 64'd0) ? '1 :
                               (op_a == 64'h8000_0000_0000_0000 && op_b == '1) ? op_a :
                               $signed(op_a) / $signed(op_b);
        MD_DIVU:   md_result = (op_b == 64'd0) ? '1 : op_a / op_b;
        MD_REM:    md_result = (op_b == 64'd0) ? op_a :
                               (op_a == 64'h8000_0000_0000_0000 && op_b == '1) ? '0 :
                               $signed(op_a) % $signed(op_b);
        MD_REMU:   md_result = (op_b == 64'd0) ? op_a : op_a % op_b;
        default:   md_result = '0;
      endcase
    end
  end
`else
  assign md_result  = '0;
  assign md_illegal = 1'b1;
`endif

  logic [63:0] pc_plus4, pc_target, jalr_target;
  logic        taken;

  assign pc_plus4    = pc_r + 64'd4;
  assign pc_target   = pc_r + imm64;
  assign jalr_target = (src1_r + imm64) & ~64'd1;

  always_comb begin
    taken = 1'b0;
    nxtpc = pc_plus4;
    case (branch_r)
      BR_JAL:  taken = 1'b1;
      BR_JALR: taken = 1'b1;
      BR_BEQ:  taken = alu_zero;
      BR_BNE:  taken = !alu_zero;
      BR_BLT:  taken = alu_result[0];
      BR_BGE:  taken = !alu_result[0];
      default: taken = 1'b0;
    endcase
    if (taken) nxtpc = (branch_r == BR_JALR) ? jalr_target : pc_target;
  end

  assign valid  = valid_r && !raise_intr;
  assign result = ctr_r[5] ? md_result : alu_result;
  assign is_jmp = (taken || csr_r) && valid_r;
  assign error  = error_r || (ctr_r[5] && md_illegal);

endmodule

// File: tb/tb_ysyx_220066_exu.sv
// Directed-vector bench for ysyx_220066_exu; expectations follow the EXU_MUL_EN build setting.
module tb_ysyx_220066_exu;

  logic        clk = 1'b0;
  logic        rst, block, valid_in, error_in;
  logic [63:0] src1_in, src2_in, csr_data_in, pc_in;
  logic [31:0] imm_in;
  logic        ALUAsrc_in;
  logic [1:0]  ALUBsrc_in;
  logic [5:0]  ALUctr_in;
  logic [2:0]  Branch_in;
  logic        csr_in, raise_intr;
  logic        valid, is_jmp, error;
  logic [63:0] result, nxtpc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_220066_exu dut (
    .clk(clk), .rst(rst), .block(block), .valid_in(valid_in), .error_in(error_in),
    .src1_in(src1_in), .src2_in(src2_in), .csr_data_in(csr_data_in), .pc_in(pc_in),
    .imm_in(imm_in), .ALUAsrc_in(ALUAsrc_in), .ALUBsrc_in(ALUBsrc_in), .ALUctr_in(ALUctr_in),
    .Branch_in(Branch_in), .csr_in(csr_in), .raise_intr(raise_intr),
    .valid(valid), .result(result), .nxtpc(nxtpc), .is_jmp(is_jmp), .error(error)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [5:0] ctr, input logic [1:0] bsrc, input logic [2:0] br,
                    input logic [63:0] s1, input logic [63:0] s2, input logic [31:0] imm,
                    input logic [63:0] pc);
    valid_in = 1'b1; error_in = 1'b0; ALUAsrc_in = 1'b0; csr_in = 1'b0;
    ALUctr_in = ctr; ALUBsrc_in = bsrc; Branch_in = br;
    src1_in = s1; src2_in = s2; imm_in = imm; pc_in = pc;
  endtask

  initial begin
    rst = 1'b1; block = 1'b0; raise_intr = 1'b0; csr_data_in = '0;
    op(6'd0, 2'b00, 3'b000, 64'd0, 64'd0, 32'd0, 64'd0);
    valid_in = 1'b0;
    tick(); tick();
    chk("rst_valid", {63'd0, valid}, 64'd0);
    chk("rst_nxtpc", nxtpc, 64'd4);
    chk("rst_result", result, 64'd0);
    chk("rst_isjmp", {63'd0, is_jmp}, 64'd0);
    chk("rst_error", {63'd0, error}, 64'd0);

    rst = 1'b0;
    tick();
    chk("idle_valid", {63'd0, valid}, 64'd0);
    chk("idle_nxtpc", nxtpc, 64'd4);
    chk("idle_isjmp", {63'd0, is_jmp}, 64'd0);

    // ALU coverage
    op(6'b010000, 2'b10, 3'b000, 64'h7FFF_FFFF, 64'd0, 32'd1, 64'h1000);
    tick();
    chk("addw", result, 64'hFFFF_FFFF_8000_0000);
    chk("addw_valid", {63'd0, valid}, 64'd1);
    chk("addw_nxtpc", nxtpc, 64'h1004);
    chk("addw_isjmp", {63'd0, is_jmp}, 64'd0);

    op(6'b001101, 2'b10, 3'b000, 64'h8000_0000_0000_0000, 64'd0, 32'd63, 64'h1000);
    tick();
    chk("sra63", result, 64'hFFFF_FFFF_FFFF_FFFF);

    op(6'b010101, 2'b10, 3'b000, 64'h1_8000_0000, 64'd0, 32'd1, 64'h1000);
    tick();
    chk("srlw", result, 64'h4000_0000);

    op(6'b000010, 2'b00, 3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 32'd0, 64'h1000);
    tick();
    chk("slt", result, 64'd1);

    op(6'b000011, 2'b00, 3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 32'd0, 64'h1000);
    tick();
    chk("sltu", result, 64'd0);

    op(6'b001110, 2'b11, 3'b000, 64'hF0, 64'd0, 32'd0, 64'h1000);
    csr_data_in = 64'hFF;
    tick();
    chk("andn", result, 64'h0F);

    op(6'b001111, 2'b01, 3'b000, 64'h123, 64'd0, 32'd0, 64'h1000);
    tick();
    chk("copyb4", result, 64'd4);

    op(6'b001001, 2'b00, 3'b000, 64'h5, 64'h3, 32'd0, 64'h1000);
    tick();
    chk("undef_op", result, 64'd0);

    // Branches
    op(6'b001000, 2'b00, 3'b100, 64'd5, 64'd5, 32'hFFFF_FFF8, 64'h8000_0000);
    tick();
    chk("beq_t_isjmp", {63'd0, is_jmp}, 64'd1);
    chk("beq_t_nxtpc", nxtpc, 64'h7FFF_FFF8);

    op(6'b001000, 2'b00, 3'b100, 64'd5, 64'd6, 32'hFFFF_FFF8, 64'h8000_0000);
    tick();
    chk("beq_nt_isjmp", {63'd0, is_jmp}, 64'd0);
    chk("beq_nt_nxtpc", nxtpc, 64'h8000_0004);

    op(6'b001000, 2'b00, 3'b101, 64'd5, 64'd6, 32'h10, 64'h8000_0000);
    tick();
    chk("bne_nxtpc", nxtpc, 64'h8000_0010);

    op(6'b000010, 2'b00, 3'b110, 64'hFFFF_FFFF_FFFF_FFFD, 64'd2, 32'h20, 64'h2000);
    tick();
    chk("blt_nxtpc", nxtpc, 64'h2020);

    op(6'b000010, 2'b00, 3'b111, 64'hFFFF_FFFF_FFFF_FFFD, 64'd2, 32'h20, 64'h2000);
    tick();
    chk("bge_nxtpc", nxtpc, 64'h2004);

    op(6'b000000, 2'b00, 3'b011, 64'd0, 64'd0, 32'h20, 64'h2000);
    tick();
    chk("br_rsvd_isjmp", {63'd0, is_jmp}, 64'd0);

    op(6'b000000, 2'b01, 3'b010, 64'h8000_1003, 64'd0, 32'd2, 64'h3000);
    ALUAsrc_in = 1'b1;
    tick();
    chk("jalr_nxtpc", nxtpc, 64'h8000_1004);
    chk("jalr_isjmp", {63'd0, is_jmp}, 64'd1);
    chk("jalr_link", result, 64'h3004);
    raise_intr = 1'b1;
    #1;
    chk("intr_valid", {63'd0, valid}, 64'd0);
    chk("intr_isjmp", {63'd0, is_jmp}, 64'd1);
    raise_intr = 1'b0;

    op(6'b000000, 2'b00, 3'b001, 64'd0, 64'd0, 32'h100, 64'h3000);
    tick();
    chk("jal_nxtpc", nxtpc, 64'h3100);

    op(6'b000000, 2'b00, 3'b000, 64'd0, 64'd0, 32'd0, 64'h3000);
    csr_in = 1'b1;
    tick();
    chk("csr_isjmp", {63'd0, is_jmp}, 64'd1);

    op(6'b000000, 2'b00, 3'b001, 64'd0, 64'd0, 32'h100, 64'h3000);
    valid_in = 1'b0;
    tick();
    chk("jal_invalid_isjmp", {63'd0, is_jmp}, 64'd0);

    op(6'b000000, 2'b00, 3'b000, 64'd0, 64'd0, 32'd0, 64'h3000);
    error_in = 1'b1;
    tick();
    chk("error_pass", {63'd0, error}, 64'd1);

    // Mul/div
    op(6'b100100, 2'b00, 3'b000, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 32'd0, 64'h0);
    tick();
`ifdef EXU_MUL_EN
    chk("div_ovf", result, 64'h8000_0000_0000_0000);
    chk("div_ovf_err", {63'd0, error}, 64'd0);
`else
    chk("div_off", result, 64'd0);
    chk("div_off_err", {63'd0, error}, 64'd1);
`endif

    op(6'b100111, 2'b00, 3'b000, 64'd7, 64'd0, 32'd0, 64'h0);
    tick();
`ifdef EXU_MUL_EN
    chk("remu_dz", result, 64'd7);
`else
    chk("remu_off", result, 64'd0);
`endif

    op(6'b100000, 2'b00, 3'b000, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 32'd0, 64'h0);
    tick();
`ifdef EXU_MUL_EN
    chk("mul", result, 64'hFFFF_FFFF_FFFF_FFFA);
`else
    chk("mul_off", result, 64'd0);
`endif

    op(6'b100011, 2'b00, 3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 32'd0, 64'h0);
    tick();
`ifdef EXU_MUL_EN
    chk("mulhu", result, 64'd1);
`else
    chk("mulhu_off", result, 64'd0);
`endif

    op(6'b110100, 2'b00, 3'b000, 64'd9, 64'd0, 32'd0, 64'h0);
    tick();
`ifdef EXU_MUL_EN
    chk("divw_dz", result, 64'hFFFF_FFFF_FFFF_FFFF);
`else
    chk("divw_off", result, 64'd0);
`endif

    op(6'b110110, 2'b00, 3'b000, 64'h8000_0000, 64'hFFFF_FFFF, 32'd0, 64'h0);
    tick();
    chk("remw_ovf", result, 64'd0);

    op(6'b110001, 2'b00, 3'b000, 64'd3, 64'd5, 32'd0, 64'h0);
    tick();
    chk("mulhw_err", {63'd0, error}, 64'd1);
    chk("mulhw_res", result, 64'd0);

    // Stall
    op(6'b000000, 2'b00, 3'b000, 64'd10, 64'd20, 32'd0, 64'h100);
    tick();
    chk("pre_stall", result, 64'd30);
    block = 1'b1;
    for (int i = 0; i < 3; i++) begin
      op(6'b000000, 2'b00, 3'b001, 64'd1, 64'd1, 32'h40, 64'h200 + 64'(i));
      valid_in = 1'b0;
      tick();
      chk("stall_result", result, 64'd30);
      chk("stall_nxtpc", nxtpc, 64'h104);
      chk("stall_valid", {63'd0, valid}, 64'd1);
    end
    op(6'b000000, 2'b00, 3'b000, 64'd1, 64'd1, 32'd0, 64'h200);
    valid_in = 1'b0;
    block = 1'b0;
    tick();
    chk("unstall_result", result, 64'd2);
    chk("unstall_nxtpc", nxtpc, 64'h204);
    chk("unstall_valid", {63'd0, valid}, 64'd0);

    op(6'b000000, 2'b00, 3'b000, 64'd7, 64'd8, 32'd0, 64'h500);
    tick();
    block = 1'b1; rst = 1'b1;
    tick();
    chk("rst_over_block_valid", {63'd0, valid}, 64'd0);
    chk("rst_over_block_result", result, 64'd0);
    chk("rst_over_block_nxtpc", nxtpc, 64'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
